// File: rtl/pc_seq.sv
// pc_seq: program-sequencing unit for the single-cycle CPU.
// Holds the program counter and selects the next address. Provides a hardware
// call/return stack, conditional branches, a HALT state, one vectored interrupt
// with an enable flag, and sticky stack overflow/underflow flags.
//
// Ports:
//   clk      - clock, all state updates on rising edge
//   reset    - asynchronous active-low reset
//   stall    - 1 = hold all state this cycle
//   op       - 000 NEXT, 001 JMP, 010 JZ, 011 JNZ, 100 CALL, 101 RET, 110 RETI, 111 HALT
//   target   - jump/call destination
//   z        - ALU zero flag
//   irq      - level-sensitive interrupt request (already synchronous)
//   ie_set   - set interrupt enable
//   ie_clr   - clear interrupt enable
//   err_clr  - clear ovf/unf
//   pc       - current instruction address
//   sp       - number of valid stack entries
//   ie       - interrupt enable
//   halted   - 1 while in HALT
//   ovf/unf  - sticky stack overflow / underflow
module pc_seq #(
  parameter int PC_W     = 10,
  parameter int DEPTH    = 8,
  parameter int RESET_PC = 0,
  parameter int IRQ_VEC  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [2:0]                 op,
  input  logic [PC_W-1:0]            target,
  input  logic                       z,
  input  logic                       irq,
  input  logic                       ie_set,
  input  logic                       ie_clr,
  input  logic                       err_clr,
  output logic [PC_W-1:0]            pc,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       ie,
  output logic                       halted,
  output logic                       ovf,
  output logic                       unf
);

  localparam int SP_W = $clog2(DEPTH+1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_NEXT = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_JNZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_RETI = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

  state_e          r_state;
  logic [PC_W-1:0] r_pc;
  logic [SP_W-1:0] r_sp;
  logic            r_ie;
  logic            r_ovf;
  logic            r_unf;
  logic [PC_W-1:0] r_stack [DEPTH];

  logic [PC_W-1:0] w_pc_inc;
  logic            w_irq_take;
  logic            w_full;
  logic            w_empty;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_rd_idx;
  logic [PC_W-1:0] w_top;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_push_val;

  assign w_pc_inc   = r_pc + 1'b1;
  assign w_irq_take = irq && r_ie && !stall;
  assign w_full     = (r_sp == SP_W'(DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_wr_idx   = AW'(r_sp);
  assign w_rd_idx   = AW'(r_sp - 1'b1);
  assign w_top      = r_stack[w_rd_idx];

  // Stack traffic decode; an interrupt pre-empts whatever op is presented.
  always_comb begin
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_push_val = w_pc_inc;
    if (!stall) begin
      if (w_irq_take) begin
        w_push = 1'b1;
        // From RUN the interrupted instruction must re-execute after RETI.
        w_push_val = (r_state == S_HALT) ? w_pc_inc : r_pc;
      end else if (r_state == S_RUN) begin
        if (op == OP_CALL) w_push = 1'b1;
        if (op == OP_RET || op == OP_RETI) w_pop = 1'b1;
      end
    end
  end

  // Stack storage carries no reset: contents are abandoned when sp clears.
  always_ff @(posedge clk) begin
    if (w_push && !w_full) r_stack[w_wr_idx] <= w_push_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_pc    <= PC_W'(RESET_PC);
      r_sp    <= '0;
      r_ie    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!stall) begin
      // Later assignments below override these (interrupt entry, RETI, new errors).
      if (ie_set && !ie_clr) r_ie <= 1'b1;
      else if (ie_clr && !ie_set) r_ie <= 1'b0;
      if (err_clr) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end

      if (w_push) begin
        if (w_full) r_ovf <= 1'b1;
        else        r_sp  <= r_sp + 1'b1;
      end
      if (w_pop) begin
        if (w_empty) r_unf <= 1'b1;
        else         r_sp  <= r_sp - 1'b1;
      end

      if (w_irq_take) begin
        r_pc    <= PC_W'(IRQ_VEC);
        r_ie    <= 1'b0;
        r_state <= S_RUN;
      end else if (r_state == S_RUN) begin
        case (op)
          OP_NEXT: r_pc <= w_pc_inc;
          OP_JMP:  r_pc <= target;
          OP_JZ:   r_pc <= z ? target : w_pc_inc;
          OP_JNZ:  r_pc <= z ? w_pc_inc : target;
          OP_CALL: r_pc <= target;
          OP_RET:  r_pc <= w_empty ? w_pc_inc : w_top;
          OP_RETI: begin
            r_pc <= w_empty ? w_pc_inc : w_top;
            r_ie <= 1'b1;
          end
          OP_HALT: r_state <= S_HALT;
          default: r_pc <= w_pc_inc;
        endcase
      end
    end
  end

  assign pc     = r_pc;
  assign sp     = r_sp;
  assign ie     = r_ie;
  assign halted = (r_state == S_HALT);
  assign ovf    = r_ovf;
  assign unf    = r_unf;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed scenarios followed by randomized traffic, each cycle
// compared against a queue-based model of the sequencer.
module tb_pc_seq;

  localparam int PC_W     = 10;
  localparam int DEPTH    = 8;
  localparam int RESET_PC = 0;
  localparam int IRQ_VEC  = 1;

  localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, JZ = 3'd2, JNZ = 3'd3,
                         CALL = 3'd4, RET = 3'd5, RETI = 3'd6, HALT = 3'd7;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic [2:0]      op;
  logic [PC_W-1:0] target;
  logic            z;
  logic            irq;
  logic            ie_set;
  logic            ie_clr;
  logic            err_clr;
  logic [PC_W-1:0] pc;
  logic [3:0]      sp;
  logic            ie;
  logic            halted;
  logic            ovf;
  logic            unf;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_stk[$];
  logic            m_ie, m_halt, m_ovf, m_unf;

  always #5 clk = ~clk;

  pc_seq #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .IRQ_VEC(IRQ_VEC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .op(op), .target(target), .z(z),
    .irq(irq), .ie_set(ie_set), .ie_clr(ie_clr), .err_clr(err_clr),
    .pc(pc), .sp(sp), .ie(ie), .halted(halted), .ovf(ovf), .unf(unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc   = PC_W'(RESET_PC);
    m_stk.delete();
    m_ie   = 1'b0;
    m_halt = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endfunction

  function automatic void model_push(input logic [PC_W-1:0] v);
    if (m_stk.size() == DEPTH) m_ovf = 1'b1;
    else m_stk.push_back(v);
  endfunction

  function automatic void model_step();
    logic [PC_W-1:0] inc;
    inc = m_pc + 1'b1;
    if (!reset) begin
      model_reset();
      return;
    end
    if (stall) return;
    if (ie_set != ie_clr) m_ie = ie_set;
    if (err_clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (irq && ie) begin
      model_push(m_halt ? inc : m_pc);
      m_pc   = PC_W'(IRQ_VEC);
      m_ie   = 1'b0;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      case (op)
        NEXT: m_pc = inc;
        JMP:  m_pc = target;
        JZ:   m_pc = z ? target : inc;
        JNZ:  m_pc = !z ? target : inc;
        CALL: begin model_push(inc); m_pc = target; end
        RET, RETI: begin
          if (m_stk.size() == 0) begin
            m_unf = 1'b1;
            m_pc  = inc;
          end else m_pc = m_stk.pop_back();
          if (op == RETI) m_ie = 1'b1;
        end
        default: m_halt = 1'b1;
      endcase
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check({tag, ".sp"}, 32'(sp), 32'(m_stk.size()));
    check({tag, ".ie"}, 32'(ie), 32'(m_ie));
    check({tag, ".halted"}, 32'(halted), 32'(m_halt));
    check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, ".unf"}, 32'(unf), 32'(m_unf));
  endtask

  task automatic idle_inputs();
    stall = 0; op = NEXT; target = '0; z = 0; irq = 0;
    ie_set = 0; ie_clr = 0; err_clr = 0;
  endtask

  // Called just after an active edge: model_step samples the inputs that the
  // DUT saw at the edge, before the DUT state is read back 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #3;
    reset = 0;
    #1;
    model_reset();
    check_all(tag);
    check({tag, ".pc0"}, 32'(pc), 32'(RESET_PC));
    #2;
    reset = 1;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    model_reset();
    #2;
    check_all("reset");
    #10;
    reset = 1;

    repeat (4) step("next");
    check("next4.pc", 32'(pc), 32'h4);

    async_reset("async_rst");

    op = JZ; target = 10'h20; z = 1;
    step("jz");
    check("jz.pc", 32'(pc), 32'h20);
    op = JNZ; target = 10'h100; z = 1;
    step("jnz");
    check("jnz.pc", 32'(pc), 32'h21);
    op = JMP; target = 10'h3FF; z = 0;
    step("jmp_top");
    op = NEXT;
    step("wrap");
    check("wrap.pc", 32'(pc), 32'h0);

    for (int i = 0; i < DEPTH; i++) begin
      op = CALL; target = PC_W'(10'h100 + 10'(i * 16));
      step("call");
    end
    check("call8.sp", 32'(sp), 32'd8);
    check("call8.ovf", 32'(ovf), 32'd0);
    target = 10'h50;
    step("call_ovf");
    check("call9.pc", 32'(pc), 32'h50);
    check("call9.ovf", 32'(ovf), 32'd1);
    op = RET;
    for (int i = 0; i < DEPTH; i++) step("ret");
    check("ret8.pc", 32'(pc), 32'h1);
    step("ret_unf");
    check("ret9.unf", 32'(unf), 32'd1);
    check("ret9.pc", 32'(pc), 32'h2);
    op = NEXT; err_clr = 1;
    step("err_clr");
    err_clr = 0;

    op = JMP; target = 10'h10; ie_set = 1;
    step("ie_set");
    ie_set = 0; op = NEXT; irq = 1;
    step("irq_run");
    check("irq.pc", 32'(pc), 32'(IRQ_VEC));
    check("irq.sp", 32'(sp), 32'd1);
    repeat (3) step("irq_masked");
    irq = 0; op = RETI;
    step("reti");
    check("reti.pc", 32'(pc), 32'h10);
    check("reti.ie", 32'(ie), 32'd1);

    op = JMP; target = 10'h30;
    step("to_halt");
    op = HALT;
    step("halt");
    op = NEXT;
    repeat (10) step("halt_hold");
    check("halt.pc", 32'(pc), 32'h30);
    check("halt.halted", 32'(halted), 32'd1);
    irq = 1;
    step("halt_irq");
    check("halt_irq.pc", 32'(pc), 32'(IRQ_VEC));
    irq = 0; op = RET;
    step("halt_ret");
    check("halt_ret.pc", 32'(pc), 32'h31);
    op = JMP; target = 10'h30; ie_clr = 1;
    step("ie_clr");
    ie_clr = 0; op = HALT;
    step("halt2");
    irq = 1; op = NEXT;
    repeat (3) step("halt_masked");
    check("halt_masked.halted", 32'(halted), 32'd1);
    ie_set = 1;
    step("halt_ieset");
    ie_set = 0;
    step("halt_irq2");
    irq = 0;

    op = CALL; target = 10'h200;
    repeat (DEPTH + 1) step("fill");
    check("fill.ovf", 32'(ovf), 32'd1);
    op = NEXT; ie_set = 1;
    step("pre_stall");
    ie_set = 0;
    stall = 1; op = CALL; irq = 1; err_clr = 1; ie_clr = 1;
    repeat (3) step("stall");
    check("stall.ovf", 32'(ovf), 32'd1);
    check("stall.ie", 32'(ie), 32'd1);
    idle_inputs();
    err_clr = 1;
    step("err_clr2");
    check("err_clr2.ovf", 32'(ovf), 32'd0);
    err_clr = 0;

    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 400) == 0) async_reset("rand_rst");
      op = 3'($urandom_range(0, 7));
      if (op == HALT && ($urandom % 4) != 0) op = NEXT;
      target  = PC_W'($urandom);
      z       = 1'($urandom);
      stall   = (($urandom % 8) == 0);
      irq     = (($urandom % 6) == 0);
      ie_set  = (($urandom % 8) == 0);
      ie_clr  = (($urandom % 10) == 0);
      err_clr = (($urandom % 16) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-sequencing unit for the single-cycle CPU: program counter, next-address selection, and a hardware call/return stack of configurable depth. Adds conditional branches, a halt state, a single vectored interrupt with enable flag, and sticky stack overflow/underflow flags. Sits between the control unit (op, z, irq) and the program memory address input (pc).

## Interface
Parameters:
- PC_W, 10, program counter / address width
- DEPTH, 8, call-stack entries (≥2)
- RESET_PC, 0, pc value after reset
- IRQ_VEC, 1, pc loaded on interrupt entry

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- stall  in  1  1 = hold all state this cycle (op and irq ignored)
- op  in  3  000 NEXT, 001 JMP, 010 JZ, 011 JNZ, 100 CALL, 101 RET, 110 RETI, 111 HALT
- target  in  PC_W  jump/call destination
- z  in  1  ALU zero flag (registered upstream)
- irq  in  1  interrupt request, level-sensitive
- ie_set  in  1  set interrupt enable
- ie_clr  in  1  clear interrupt enable
- err_clr  in  1  clear ovf/unf
- pc  out  PC_W  current instruction address
- sp  out  $clog2(DEPTH+1)  number of valid stack entries
- ie  out  1  interrupt enable
- halted  out  1  1 while in HALT state
- ovf  out  1  sticky: push attempted with sp==DEPTH
- unf  out  1  sticky: pop attempted with sp==0

## Operation
- Reset (reset=0, async): pc=RESET_PC, sp=0, ie=0, halted=0, ovf=0, unf=0; stack contents don't-care.
- States: RUN, HALT. halted=1 iff HALT.
- RUN, no interrupt taken, by op:
  - NEXT: pc←pc+1. JMP: pc←target.
  - JZ: pc←target if z else pc+1. JNZ: pc←target if !z else pc+1.
  - CALL: push pc+1, pc←target.
  - RET: pop, pc←popped value. RETI: as RET, plus ie←1.
  - HALT: pc unchanged, state←HALT.
- Interrupt taken when irq&&ie&&!stall (RUN or HALT); takes priority over op:
  - RUN: push pc (interrupted instruction re-executes after RETI), pc←IRQ_VEC, ie←0.
  - HALT: push pc+1, pc←IRQ_VEC, ie←0, state←RUN.
- HALT without interrupt: pc held; only interrupt or reset leaves.
- Stack: LIFO, push writes entry[sp], sp+1; pop reads entry[sp-1], sp-1.
  - Push with sp==DEPTH: ovf←1, stack and sp unchanged, pc update still performed.
  - Pop with sp==0: unf←1, sp stays 0, pc←pc+1 (RETI still sets ie).
- ie: ie_set/ie_clr honoured when not stalled; interrupt entry clear and RETI set override both; ie_set and ie_clr together → ie unchanged.
- err_clr clears ovf/unf; new error in same cycle wins (flag stays 1).
- Arithmetic: pc+1 modulo 2^PC_W (all-ones wraps to 0).
- stall=1: pc, sp, stack, state, ie, ovf, unf all held; err_clr also ignored.

## Timing
- All outputs registered; one-cycle latency from op/target/z/irq to new pc.
- Popped value read combinationally from stack array, registered into pc same edge.
- irq sampled each edge; no internal synchronisation (caller supplies synchronous irq).
- Reset deassertion: first edge with reset=1 executes op at RESET_PC.
- Reset asserted mid-call-chain: sp→0 immediately, stack contents abandoned.

## Test plan
- Reset then 4×NEXT from RESET_PC=0 → pc 0,1,2,3,4; sp=0, flags 0; async reset mid-run → pc=0 without clock edge.
- JZ target=0x20 with z=1 → pc=0x20; JNZ same cycle-equivalent with z=1 → pc=prev+1; pc=0x3FF NEXT → pc=0.
- Nested CALLs DEPTH=8: 8 calls → sp=8, ovf=0; 9th CALL target=0x50 → pc=0x50, sp=8, ovf=1; 8 RETs return addresses in reverse order; 9th RET → unf=1, pc=pc+1; err_clr → flags 0.
- ie_set, irq at pc=0x10 → pc=IRQ_VEC, sp=1, ie=0; irq held with ie=0 → no re-entry; RETI → pc=0x10, ie=1.
- HALT at pc=0x30 → halted=1, pc stays 0x30 for 10 cycles; irq with ie=1 → halted=0, pc=IRQ_VEC, stack top 0x31; irq with ie=0 → remains halted.
- stall=1 with op=CALL and irq asserted → pc, sp, ie unchanged; err_clr with ovf=1 and stall=1 → ovf stays 1.
